// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one requester of the data-memory arbiter.
interface dmem_arbiter_if;
    logic        req_valid;
    logic        req_ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Requester side
    modport master (
        output req_valid, we, addr, wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Arbiter side
    modport slave (
        input  req_valid, we, addr, wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Combinational grant and memory drive; one-cycle registered response.
module dmem_arbiter #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave p0,
    dmem_arbiter_if.slave p1,
    output logic          mem_w_en,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_w_data,
    input  logic [31:0]   mem_r_data
);
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    port_e       last_q, last_d;
    logic        gnt0, gnt1;
    logic        sel_we, sel_err;
    logic [31:0] sel_addr, sel_wdata, load_data;

    logic        p0_rsp_valid_q, p0_rsp_valid_d;
    logic        p0_rsp_err_q,   p0_rsp_err_d;
    logic [31:0] p0_rsp_rdata_q, p0_rsp_rdata_d;
    logic        p1_rsp_valid_q, p1_rsp_valid_d;
    logic        p1_rsp_err_q,   p1_rsp_err_d;
    logic [31:0] p1_rsp_rdata_q, p1_rsp_rdata_d;

    // Grant selection, request mux, address check and memory drive
    always_comb begin
        gnt0      = p0.req_valid & (~p1.req_valid | (last_q == PORT1));
        gnt1      = p1.req_valid & ~gnt0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt0) begin
            sel_we    = p0.we;
            sel_addr  = p0.addr;
            sel_wdata = p0.wdata;
        end else if (gnt1) begin
            sel_we    = p1.we;
            sel_addr  = p1.addr;
            sel_wdata = p1.wdata;
        end
        sel_err      = (gnt0 | gnt1) &
                       ((sel_addr[1:0] != 2'b00) | (sel_addr >= ADDR_LIMIT));
        mem_w_en     = sel_we & ~sel_err;
        mem_addr     = 32'(sel_addr[IDX_W+1:2]);
        mem_w_data   = sel_wdata;
        p0.req_ready = gnt0;
        p1.req_ready = gnt1;
    end

    // Next-state for last-grant pointer and per-port responses
    always_comb begin
        last_d = last_q;
        if (gnt0) begin
            last_d = PORT0;
        end else if (gnt1) begin
            last_d = PORT1;
        end
        load_data      = (~sel_we & ~sel_err) ? mem_r_data : '0;
        p0_rsp_valid_d = gnt0;
        p0_rsp_err_d   = gnt0 & sel_err;
        p0_rsp_rdata_d = gnt0 ? load_data : '0;
        p1_rsp_valid_d = gnt1;
        p1_rsp_err_d   = gnt1 & sel_err;
        p1_rsp_rdata_d = gnt1 ? load_data : '0;
    end

    // State registers; reset drops any pending response and favours port 0
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q         <= PORT1;
            p0_rsp_valid_q <= 1'b0;
            p0_rsp_err_q   <= 1'b0;
            p0_rsp_rdata_q <= '0;
            p1_rsp_valid_q <= 1'b0;
            p1_rsp_err_q   <= 1'b0;
            p1_rsp_rdata_q <= '0;
        end else begin
            last_q         <= last_d;
            p0_rsp_valid_q <= p0_rsp_valid_d;
            p0_rsp_err_q   <= p0_rsp_err_d;
            p0_rsp_rdata_q <= p0_rsp_rdata_d;
            p1_rsp_valid_q <= p1_rsp_valid_d;
            p1_rsp_err_q   <= p1_rsp_err_d;
            p1_rsp_rdata_q <= p1_rsp_rdata_d;
        end
    end

    assign p0.rsp_valid = p0_rsp_valid_q;
    assign p0.rsp_err   = p0_rsp_err_q;
    assign p0.rsp_rdata = p0_rsp_rdata_q;
    assign p1.rsp_valid = p1_rsp_valid_q;
    assign p1.rsp_err   = p1_rsp_err_q;
    assign p1.rsp_rdata = p1_rsp_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 32-word memory model that preloads
// word i with 0xA0000000+i while rst is high.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_w_en;
    logic [31:0] mem_addr, mem_w_data, mem_r_data;
    logic [31:0] mem [0:31];
    int          n_chk  = 0;
    int          n_fail = 0;

    dmem_arbiter_if p0_if ();
    dmem_arbiter_if p1_if ();

    dmem_arbiter #(.DEPTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .p0         (p0_if),
        .p1         (p1_if),
        .mem_w_en   (mem_w_en),
        .mem_addr   (mem_addr),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, synchronous write, preload on reset
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else if (mem_w_en) begin
            mem[mem_addr[4:0]] <= mem_w_data;
        end
    end
    assign mem_r_data = mem[mem_addr[4:0]];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        p0_if.req_valid = v; p0_if.we = we; p0_if.addr = a; p0_if.wdata = d;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        p1_if.req_valid = v; p1_if.we = we; p1_if.addr = a; p1_if.wdata = d;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        cyc();
        cyc();
        mid();
        n_chk++; if (p0_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_p0_rsp_valid got=%b exp=0", p0_if.rsp_valid); end
        n_chk++; if (p1_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_p1_rsp_valid got=%b exp=0", p1_if.rsp_valid); end
        n_chk++; if (p0_if.rsp_err !== 1'b0 || p1_if.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err got=%b%b exp=00", p0_if.rsp_err, p1_if.rsp_err); end
        n_chk++; if (p0_if.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_p0_rdata got=%h exp=0", p0_if.rsp_rdata); end
        n_chk++; if (mem_w_en !== 1'b0 || mem_addr !== 32'h0 || mem_w_data !== 32'h0) begin n_fail++; $display("FAIL rst_mem got=%b/%h/%h exp=0/0/0", mem_w_en, mem_addr, mem_w_data); end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        do_reset();
        drive0(1'b1, 1'b1, 32'h08, 32'hDEAD_BEEF);
        mid();
        n_chk++; if (p0_if.req_ready !== 1'b1 || p1_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL sl_ready got=%b%b exp=10", p0_if.req_ready, p1_if.req_ready); end
        n_chk++; if (mem_w_en !== 1'b1 || mem_addr !== 32'd2 || mem_w_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sl_store_mem got=%b/%h/%h exp=1/2/deadbeef", mem_w_en, mem_addr, mem_w_data); end
        cyc();
        n_chk++; if (p0_if.rsp_valid !== 1'b1 || p0_if.rsp_err !== 1'b0 || p0_if.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL sl_store_rsp got=%b/%b/%h exp=1/0/0", p0_if.rsp_valid, p0_if.rsp_err, p0_if.rsp_rdata); end
        drive0(1'b1, 1'b0, 32'h08, 32'h0);
        mid();
        n_chk++; if (mem_w_en !== 1'b0 || mem_addr !== 32'd2) begin n_fail++; $display("FAIL sl_load_mem got=%b/%h exp=0/2", mem_w_en, mem_addr); end
        cyc();
        n_chk++; if (p0_if.rsp_valid !== 1'b1 || p0_if.rsp_err !== 1'b0 || p0_if.rsp_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sl_load_rsp got=%b/%b/%h exp=1/0/deadbeef", p0_if.rsp_valid, p0_if.rsp_err, p0_if.rsp_rdata); end
        drive0(1'b0, 1'b0, '0, '0);
        cyc();
        n_chk++; if (p0_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sl_rsp_one_cycle got=%b exp=0", p0_if.rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic exp1;
        do_reset();
        drive0(1'b1, 1'b0, 32'h10, '0);
        drive1(1'b1, 1'b0, 32'h14, '0);
        for (int i = 0; i < 4; i++) begin
            exp1 = (i % 2) == 1;
            mid();
            n_chk++; if (p0_if.req_ready !== ~exp1 || p1_if.req_ready !== exp1) begin n_fail++; $display("FAIL rr_ready[%0d] got=%b%b exp=%b%b", i, p0_if.req_ready, p1_if.req_ready, ~exp1, exp1); end
            cyc();
            n_chk++; if (p0_if.rsp_valid !== ~exp1 || p1_if.rsp_valid !== exp1) begin n_fail++; $display("FAIL rr_rsp_valid[%0d] got=%b%b exp=%b%b", i, p0_if.rsp_valid, p1_if.rsp_valid, ~exp1, exp1); end
            n_chk++; if ((exp1 ? p1_if.rsp_rdata : p0_if.rsp_rdata) !== (exp1 ? 32'hA000_0005 : 32'hA000_0004)) begin n_fail++; $display("FAIL rr_rdata[%0d] got=%h/%h", i, p0_if.rsp_rdata, p1_if.rsp_rdata); end
        end
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        cyc();
        n_chk++; if (p0_if.rsp_valid !== 1'b0 || p1_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle got=%b%b exp=00", p0_if.rsp_valid, p1_if.rsp_valid); end
    endtask

    task automatic test_errors();
        drive1(1'b1, 1'b1, 32'h06, 32'h1234_5678);
        mid();
        n_chk++; if (p1_if.req_ready !== 1'b1 || mem_w_en !== 1'b0) begin n_fail++; $display("FAIL err_mis_grant got=%b/%b exp=1/0", p1_if.req_ready, mem_w_en); end
        cyc();
        n_chk++; if (p1_if.rsp_valid !== 1'b1 || p1_if.rsp_err !== 1'b1 || p1_if.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL err_mis_rsp got=%b/%b/%h exp=1/1/0", p1_if.rsp_valid, p1_if.rsp_err, p1_if.rsp_rdata); end
        drive1(1'b1, 1'b1, 32'h80, 32'h1234_5678);
        mid();
        n_chk++; if (p1_if.req_ready !== 1'b1 || mem_w_en !== 1'b0) begin n_fail++; $display("FAIL err_oor_grant got=%b/%b exp=1/0", p1_if.req_ready, mem_w_en); end
        cyc();
        n_chk++; if (p1_if.rsp_valid !== 1'b1 || p1_if.rsp_err !== 1'b1 || p1_if.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL err_oor_rsp got=%b/%b/%h exp=1/1/0", p1_if.rsp_valid, p1_if.rsp_err, p1_if.rsp_rdata); end
        drive1(1'b1, 1'b0, 32'h80, '0);
        cyc();
        n_chk++; if (p1_if.rsp_valid !== 1'b1 || p1_if.rsp_err !== 1'b1 || p1_if.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL err_oor_load got=%b/%b/%h exp=1/1/0", p1_if.rsp_valid, p1_if.rsp_err, p1_if.rsp_rdata); end
        drive1(1'b1, 1'b0, 32'h7C, '0);
        cyc();
        n_chk++; if (p1_if.rsp_err !== 1'b0 || p1_if.rsp_rdata !== 32'hA000_001F) begin n_fail++; $display("FAIL err_last_word got=%b/%h exp=0/a000001f", p1_if.rsp_err, p1_if.rsp_rdata); end
        drive1(1'b0, 1'b0, '0, '0);
        mid();
        n_chk++; if (mem[1] !== 32'hA000_0001 || mem[0] !== 32'hA000_0000) begin n_fail++; $display("FAIL err_mem_intact got=%h/%h exp=a0000001/a0000000", mem[1], mem[0]); end
    endtask

    task automatic test_p1_alone();
        drive1(1'b1, 1'b0, 32'h0C, '0);
        for (int i = 0; i < 3; i++) begin
            mid();
            n_chk++; if (p1_if.req_ready !== 1'b1 || p0_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL p1a_ready[%0d] got=%b%b exp=01", i, p0_if.req_ready, p1_if.req_ready); end
            cyc();
            n_chk++; if (p1_if.rsp_valid !== 1'b1 || p1_if.rsp_rdata !== 32'hA000_0003) begin n_fail++; $display("FAIL p1a_rsp[%0d] got=%b/%h exp=1/a0000003", i, p1_if.rsp_valid, p1_if.rsp_rdata); end
        end
        drive0(1'b1, 1'b0, 32'h04, '0);
        mid();
        n_chk++; if (p0_if.req_ready !== 1'b1 || p1_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL p1a_join got=%b%b exp=10", p0_if.req_ready, p1_if.req_ready); end
        cyc();
        n_chk++; if (p0_if.rsp_valid !== 1'b1 || p1_if.rsp_valid !== 1'b0 || p0_if.rsp_rdata !== 32'hA000_0001) begin n_fail++; $display("FAIL p1a_join_rsp got=%b%b/%h exp=10/a0000001", p0_if.rsp_valid, p1_if.rsp_valid, p0_if.rsp_rdata); end
        drive0(1'b0, 1'b0, '0, '0);
        mid();
        n_chk++; if (p1_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL p1a_resume got=%b exp=1", p1_if.req_ready); end
        drive1(1'b0, 1'b0, '0, '0);
        cyc();
    endtask

    task automatic test_back_to_back();
        drive0(1'b1, 1'b1, 32'h10, 32'hCAFE_F00D);
        cyc();
        n_chk++; if (p0_if.rsp_valid !== 1'b1 || p0_if.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL b2b_store got=%b/%h exp=1/0", p0_if.rsp_valid, p0_if.rsp_rdata); end
        drive0(1'b1, 1'b0, 32'h10, '0);
        mid();
        n_chk++; if (p0_if.req_ready !== 1'b1 || p0_if.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_overlap got=%b/%b exp=1/1", p0_if.req_ready, p0_if.rsp_valid); end
        cyc();
        n_chk++; if (p0_if.rsp_valid !== 1'b1 || p0_if.rsp_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_load1 got=%b/%h exp=1/cafef00d", p0_if.rsp_valid, p0_if.rsp_rdata); end
        drive0(1'b1, 1'b0, 32'h14, '0);
        cyc();
        n_chk++; if (p0_if.rsp_valid !== 1'b1 || p0_if.rsp_rdata !== 32'hA000_0005) begin n_fail++; $display("FAIL b2b_load2 got=%b/%h exp=1/a0000005", p0_if.rsp_valid, p0_if.rsp_rdata); end
        drive0(1'b0, 1'b0, '0, '0);
        cyc();
    endtask

    task automatic test_reset_mid();
        drive0(1'b1, 1'b0, 32'h08, '0);
        cyc();
        n_chk++; if (p0_if.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre got=%b exp=1", p0_if.rsp_valid); end
        drive0(1'b1, 1'b0, 32'h0C, '0);
        rst = 1'b1;
        cyc();
        n_chk++; if (p0_if.rsp_valid !== 1'b0 || p0_if.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rm_dropped got=%b/%h exp=0/0", p0_if.rsp_valid, p0_if.rsp_rdata); end
        rst = 1'b0;
        drive0(1'b1, 1'b0, 32'h08, '0);
        drive1(1'b1, 1'b0, 32'h0C, '0);
        mid();
        n_chk++; if (p0_if.req_ready !== 1'b1 || p1_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL rm_first_tie got=%b%b exp=10", p0_if.req_ready, p1_if.req_ready); end
        cyc();
        n_chk++; if (p0_if.rsp_valid !== 1'b1 || p0_if.rsp_rdata !== 32'hA000_0002) begin n_fail++; $display("FAIL rm_after got=%b/%h exp=1/a0000002", p0_if.rsp_valid, p0_if.rsp_rdata); end
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        cyc();
    endtask

    task automatic test_same_word();
        do_reset();
        drive0(1'b1, 1'b1, 32'h7C, 32'h11);
        drive1(1'b1, 1'b0, 32'h7C, '0);
        mid();
        n_chk++; if (p0_if.req_ready !== 1'b1 || p1_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL sw_ready got=%b%b exp=10", p0_if.req_ready, p1_if.req_ready); end
        n_chk++; if (mem_w_en !== 1'b1 || mem_addr !== 32'd31) begin n_fail++; $display("FAIL sw_mem got=%b/%h exp=1/1f", mem_w_en, mem_addr); end
        cyc();
        n_chk++; if (p0_if.rsp_valid !== 1'b1 || p0_if.rsp_err !== 1'b0) begin n_fail++; $display("FAIL sw_store_rsp got=%b/%b exp=1/0", p0_if.rsp_valid, p0_if.rsp_err); end
        drive0(1'b0, 1'b0, '0, '0);
        mid();
        n_chk++; if (p1_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL sw_p1_grant got=%b exp=1", p1_if.req_ready); end
        cyc();
        n_chk++; if (p1_if.rsp_valid !== 1'b1 || p1_if.rsp_rdata !== 32'h11 || p1_if.rsp_err !== 1'b0) begin n_fail++; $display("FAIL sw_load_rsp got=%b/%h/%b exp=1/11/0", p1_if.rsp_valid, p1_if.rsp_rdata, p1_if.rsp_err); end
        drive1(1'b0, 1'b0, '0, '0);
        cyc();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_round_robin();
        test_errors();
        test_p1_alone();
        test_back_to_back();
        test_reset_mid();
        test_same_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
